// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU function codes,
// opcode/funct values, datapath mux selects and the control FSM states.
package mips_pkg;

  // ALU operation encoding driven on alu_func
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_NOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_LUI  = 3'd6;
  localparam logic [2:0] ALU_ZERO = 3'd7;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC load source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_RTYPEEX,
    S_RTYPEWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
  } state_t;

  // What the ALU is being used for in the current step; selects how the
  // function decoder interprets opcode/funct.
  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_RTYPE,
    ALU_CLS_IMM
  } alu_cls_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the
// instruction register / datapath / memory port (slave).
interface multicycle_control_if;
  import mips_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       imm_zext;
  logic [2:0] alu_func;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal_op;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, imm_zext, alu_func,
           reg_dst, mem_to_reg, reg_write, illegal_op
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_en, pc_source,
           alu_src_a, alu_src_b, imm_zext, alu_func,
           reg_dst, mem_to_reg, reg_write, illegal_op
  );

endinterface

// File: rtl/multicycle_control_alu_func_decode.sv
// Purely combinational ALU function decoder. The class input says how the
// ALU is used this step; valid_o flags whether opcode/funct is a supported
// instruction at all, independent of the class.
module alu_func_decode
  import mips_pkg::*;
(
  input  alu_cls_t   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_func_o,
  output logic       imm_zext_o,
  output logic       valid_o
);

  logic [2:0] rtype_func;
  logic       rtype_ok;

  // R-type funct to ALU operation
  always_comb begin
    rtype_func = ALU_ZERO;
    rtype_ok   = 1'b1;
    case (funct_i)
      FN_ADD:  rtype_func = ALU_ADD;
      FN_SUB:  rtype_func = ALU_SUB;
      FN_AND:  rtype_func = ALU_AND;
      FN_OR:   rtype_func = ALU_OR;
      FN_NOR:  rtype_func = ALU_NOR;
      FN_SLT:  rtype_func = ALU_SLT;
      default: rtype_ok   = 1'b0;
    endcase
  end

  // Instruction legality, independent of which step is asking
  always_comb begin
    valid_o = 1'b0;
    case (opcode_i)
      OP_RTYPE:                   valid_o = rtype_ok;
      OP_LW, OP_SW, OP_BEQ,
      OP_BNE, OP_J, OP_ADDI,
      OP_ANDI, OP_ORI, OP_SLTI,
      OP_LUI:                     valid_o = 1'b1;
      default:                    valid_o = 1'b0;
    endcase
  end

  // ALU function and immediate extension for the requested class
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block can leave a value unassigned and infer a latch.
    alu_func_o = ALU_ADD;
    imm_zext_o = 1'b0;
    case (cls_i)
      ALU_CLS_ADD:   alu_func_o = ALU_ADD;
      ALU_CLS_SUB:   alu_func_o = ALU_SUB;
      ALU_CLS_RTYPE: alu_func_o = rtype_func;
      ALU_CLS_IMM: begin
        case (opcode_i)
          OP_ADDI: alu_func_o = ALU_ADD;
          OP_SLTI: alu_func_o = ALU_SLT;
          OP_LUI:  alu_func_o = ALU_LUI;
          OP_ANDI: begin
            alu_func_o = ALU_AND;
            imm_zext_o = 1'b1;
          end
          OP_ORI: begin
            alu_func_o = ALU_OR;
            imm_zext_o = 1'b1;
          end
          default: alu_func_o = ALU_ZERO;
        endcase
      end
      default:       alu_func_o = ALU_ZERO;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the datapath selects. Outputs are Moore except
// ir_write/pc_en in FETCH (memory handshake) and pc_en in BRANCH (zero flag).
module multicycle_control
  import mips_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        ctrl
);

  state_t     state_q;
  state_t     state_d;
  alu_cls_t   alu_cls;
  logic [2:0] dec_alu_func;
  logic       dec_imm_zext;
  logic       dec_valid;

  alu_func_decode u_alu_func_decode (
    .cls_i      (alu_cls),
    .opcode_i   (ctrl.opcode),
    .funct_i    (ctrl.funct),
    .alu_func_o (dec_alu_func),
    .imm_zext_o (dec_imm_zext),
    .valid_o    (dec_valid)
  );

  // State register; reset wins over any pending memory handshake
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // ALU usage class for the current step
  always_comb begin
    alu_cls = ALU_CLS_ADD;
    case (state_q)
      S_RTYPEEX: alu_cls = ALU_CLS_RTYPE;
      S_IMMEX:   alu_cls = ALU_CLS_IMM;
      S_BRANCH:  alu_cls = ALU_CLS_SUB;
      default:   alu_cls = ALU_CLS_ADD;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    ctrl.mem_req    = 1'b0;
    ctrl.mem_we     = 1'b0;
    ctrl.iord       = 1'b0;
    ctrl.ir_write   = 1'b0;
    ctrl.pc_en      = 1'b0;
    ctrl.pc_source  = PCSRC_ALU;
    ctrl.alu_src_a  = 1'b0;
    ctrl.alu_src_b  = SRCB_REGB;
    ctrl.imm_zext   = dec_imm_zext;
    ctrl.alu_func   = dec_alu_func;
    ctrl.reg_dst    = 1'b0;
    ctrl.mem_to_reg = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = ctrl.mem_ready;
        ctrl.pc_en     = ctrl.mem_ready;
        if (ctrl.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here
        ctrl.alu_src_b = SRCB_IMM_SH2;
        if (!dec_valid) begin
          ctrl.illegal_op = 1'b1;
          state_d         = S_FETCH;
        end else begin
          case (ctrl.opcode)
            OP_LW, OP_SW:      state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_RTYPEEX;
            OP_BEQ, OP_BNE:    state_d = S_BRANCH;
            OP_J:              state_d = S_JUMP;
            OP_ADDI, OP_ANDI,
            OP_ORI, OP_SLTI,
            OP_LUI:            state_d = S_IMMEX;
            default:           state_d = S_FETCH;
          endcase
        end
      end

      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (ctrl.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.mem_req = 1'b1;
        if (ctrl.mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end

      S_MEMWR: begin
        ctrl.iord    = 1'b1;
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        if (ctrl.mem_ready) state_d = S_FETCH;
      end

      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        state_d        = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end

      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_en     = (ctrl.opcode == OP_BNE) ? !ctrl.zero_flag : ctrl.zero_flag;
        state_d        = S_FETCH;
      end

      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_IMMWB;
      end

      S_IMMWB: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end

      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_en     = 1'b1;
        state_d        = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    // zero-extension is only meaningful while executing an immediate op
    if (state_q != S_IMMEX) ctrl.imm_zext = 1'b0;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each task walks one instruction
// (or scenario) cycle by cycle and compares the full output vector against
// hand-written per-state signatures.
module tb_multicycle_control;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector, field order:
  // req we iord irw pce pcs[1:0] srca srcb[1:0] zx fn[2:0] rd m2r rw ill
  logic [17:0] obs;
  assign obs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_en,
                bus.pc_source, bus.alu_src_a, bus.alu_src_b, bus.imm_zext,
                bus.alu_func, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                bus.illegal_op};

  //                               req   we    iord  irw   pce   pcs    srca  srcb   zx    fn    rd    m2r   rw    ill
  localparam logic [17:0] F_W   = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] F_R   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] DEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] DEC_I = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [17:0] MADR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] MRD   = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] MWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [17:0] MWR   = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [17:0] RWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [17:0] IWB   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [17:0] JMP   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [17:0] rex(input logic [2:0] fn);
    return {5'b00000, 2'b00, 1'b1, 2'b00, 1'b0, fn, 4'b0000};
  endfunction

  function automatic logic [17:0] iex(input logic [2:0] fn, input logic zx);
    return {5'b00000, 2'b00, 1'b1, 2'b10, zx, fn, 4'b0000};
  endfunction

  function automatic logic [17:0] br(input logic pce);
    return {4'b0000, pce, 2'b01, 1'b1, 2'b00, 1'b0, 3'd1, 4'b0000};
  endfunction

  // One reset cycle, leaving the FSM in FETCH just after a rising edge
  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero_flag = 1'b0;
    bus.opcode    = OP_J;
    bus.funct     = 6'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (obs !== F_R) begin
      n_fail++;
      $display("FAIL reset_fetch_ready: got %h expected %h", obs, F_R);
    end
    bus.mem_ready = 1'b0;
    #1;
    n_checks++;
    if (obs !== F_W) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", obs, F_W);
    end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== F_R) begin
      n_fail++;
      $display("FAIL release_fetch: got %h expected %h", obs, F_R);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (obs !== DEC) begin
      n_fail++;
      $display("FAIL release_decode: got %h expected %h", obs, DEC);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (obs !== JMP) begin
      n_fail++;
      $display("FAIL jump: got %h expected %h", obs, JMP);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (obs !== F_R) begin
      n_fail++;
      $display("FAIL jump_return: got %h expected %h", obs, F_R);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_rtype();
    logic [5:0]  fns [6] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT};
    logic [2:0]  alu [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [17:0] exp [5];
    for (int k = 0; k < 6; k++) begin
      do_reset();
      bus.opcode    = OP_RTYPE;
      bus.funct     = fns[k];
      bus.mem_ready = 1'b1;
      exp = '{F_R, DEC, rex(alu[k]), RWB, F_R};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL rtype funct=%h cycle %0d: got %h expected %h", fns[k], i, obs, exp[i]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [17:0] exp [9] = '{F_R, DEC, MADR, MRD, MRD, MRD, MRD, MWB, F_W};
    logic        mr  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    bus.opcode = OP_LW;
    bus.funct  = 6'h00;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = mr[i];
      @(negedge clk);
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL lw_wait cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sw();
    logic [17:0] exp [8] = '{F_W, F_W, F_R, DEC, MADR, MWR, MWR, F_R};
    logic        mr  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    bus.opcode = OP_SW;
    bus.funct  = 6'h00;
    for (int i = 0; i < 8; i++) begin
      bus.mem_ready = mr[i];
      @(negedge clk);
      n_checks++;
      if (obs !== exp[i]) begin
        n_fail++;
        $display("FAIL sw cycle %0d: got %h expected %h", i, obs, exp[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0]  ops [4] = '{OP_BEQ, OP_BNE, OP_BEQ, OP_BNE};
    logic        zfs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        pce [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [17:0] exp [4];
    for (int k = 0; k < 4; k++) begin
      do_reset();
      bus.opcode    = ops[k];
      bus.funct     = 6'h00;
      bus.zero_flag = zfs[k];
      bus.mem_ready = 1'b1;
      exp = '{F_R, DEC, br(pce[k]), F_R};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL branch op=%h zf=%0d cycle %0d: got %h expected %h", ops[k], zfs[k], i, obs, exp[i]);
        end
        @(posedge clk);
        #1;
      end
    end
    bus.zero_flag = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0]  ops [5] = '{OP_LUI, OP_ORI, OP_ADDI, OP_ANDI, OP_SLTI};
    logic [2:0]  alu [5] = '{3'd6, 3'd3, 3'd0, 3'd2, 3'd5};
    logic        zx  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [17:0] exp [5];
    for (int k = 0; k < 5; k++) begin
      do_reset();
      bus.opcode    = ops[k];
      bus.funct     = 6'h3F;
      bus.mem_ready = 1'b1;
      exp = '{F_R, DEC, iex(alu[k], zx[k]), IWB, F_R};
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL imm op=%h cycle %0d: got %h expected %h", ops[k], i, obs, exp[i]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  ops [2] = '{6'h3F, OP_RTYPE};
    logic [5:0]  fns [2] = '{6'h20, 6'h01};
    logic [17:0] exp [3] = '{F_R, DEC_I, F_R};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.opcode    = ops[k];
      bus.funct     = fns[k];
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp[i]) begin
          n_fail++;
          $display("FAIL illegal op=%h funct=%h cycle %0d: got %h expected %h", ops[k], fns[k], i, obs, exp[i]);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Reset arriving while a memory access is outstanding
  task automatic test_reset_mid();
    logic [5:0]  ops [2] = '{OP_SW, OP_LW};
    logic [17:0] exp [2][6] = '{'{F_R, DEC, MADR, MWR, MWR, F_W},
                                '{F_R, DEC, MADR, MRD, MRD, F_W}};
    logic        mr  [2][6] = '{'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
                                '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}};
    logic        rst [6]    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      bus.opcode = ops[k];
      bus.funct  = 6'h00;
      for (int i = 0; i < 6; i++) begin
        reset         = rst[i];
        bus.mem_ready = mr[k][i];
        @(negedge clk);
        n_checks++;
        if (obs !== exp[k][i]) begin
          n_fail++;
          $display("FAIL reset_mid op=%h cycle %0d: got %h expected %h", ops[k], i, obs, exp[k][i]);
        end
        @(posedge clk);
        #1;
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b0;

    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch();
    test_imm();
    test_illegal();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
